pia_button_conditioner: RTL and testbench
=========================================

// Module: pia_button_conditioner
// PURPOSE
//  Conditions the raw board buttons feeding the PIA: 2-flop sync, per-bit debounce,
//  power-on settle. Drives the PIA active-low `buttons` vector (SWCHA/SWCHB source)
//  and its `ready` input. Sits between the board pins and pia.
// PARAMETERS
//  NUM_BUTTONS      8        width of button vector; bit map UP=4 DOWN=5 LEFT=6 RIGHT=7 A=3 B=1 X=0 Y=2
//  DEBOUNCE_CYCLES  250000   consecutive mismatching clocks before a bit flips; minimum 1
//  STARTUP_CYCLES   1048576  clocks after reset release before ready_o rises; minimum 1
// PORTS
//  clk_i      in   1            system clock; the only clock
//  rst_ni     in   1            reset, synchronous, active-low
//  btn_i      in   NUM_BUTTONS  raw asynchronous buttons, 1 = pressed
//  buttons_o  out  NUM_BUTTONS  conditioned buttons to pia, 0 = pressed
//  ready_o    out  1            settle period complete; to pia `ready`
//  changed_o  out  1            1-clock pulse when buttons_o takes a new value
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge), values after that edge:
//   sync regs 0, stable 0 (released), debounce counters 0, startup counter 0,
//   ready_o 0, buttons_o all-ones, changed_o 0. Reset mid-debounce discards progress.
//  Sync: sync1 <= btn_i, sync2 <= sync1. sync2 is the only value debounce logic sees.
//  Debounce, per bit i, independent:
//   sync2[i]==stable[i]: cnt[i] <= 0.
//   Otherwise: if cnt[i]==DEBOUNCE_CYCLES-1, stable[i] <= sync2[i] and cnt[i] <= 0;
//   else cnt[i] <= cnt[i]+1.
//   cnt width = $clog2(DEBOUNCE_CYCLES+1). A single matching cycle restarts the count.
//   Latency: raw change captured into sync1 at edge k makes stable flip at edge
//   k+DEBOUNCE_CYCLES+1. buttons_o shows it after the same edge.
//   Glitches shorter than DEBOUNCE_CYCLES clocks at sync2 are never seen.
//  Startup counter:
//   Increments each clock while ready_o is 0.
//   ready_o <= 1 at the edge where the count reaches STARTUP_CYCLES-1.
//   ready_o then stays 1 until reset; the counter saturates (does not wrap).
//   Debouncing runs during startup, so stable is already valid when ready_o rises.
//  Output: buttons_o = ready_o ? ~filt(stable) : all-ones.
//   buttons_o comes from registers only; there is no combinational path from btn_i.
//  changed_o:
//   changed_o = ready_o & ready_q & (buttons_o != prev_q).
//   prev_q and ready_q are the previous-clock values of buttons_o and ready_o.
//   No pulse on the ready_o rising clock, and no pulse during reset.
//   Several bits flipping on the same clock give one pulse.
//  Simultaneous flips of several bits on the same edge all take effect together.
// CONFIGURATION
//  SOCD_FILTER_EN defined:
//   filt() clears bits 6 and 7 of the pressed vector when both LEFT and RIGHT are pressed.
//   It clears bits 4 and 5 when both UP and DOWN are pressed. Cleared bits read as 1 on buttons_o.
//   Other bits pass through. The filter acts after debounce; changed_o follows the filtered output.
//  SOCD_FILTER_EN undefined: filt() is identity and opposing directions pass through unchanged.
// TESTING  (DEBOUNCE_CYCLES=4, STARTUP_CYCLES=16)
//  1 Reset, btn_i=8'h00 -> ready_o rises exactly 16 clocks after the reset-release edge.
//    buttons_o=8'hFF throughout, changed_o never pulses.
//  2 After ready, btn_i=8'h10 held -> buttons_o=8'hEF exactly 5 edges after the sync1 capture edge.
//    changed_o pulses once for one clock.
//  3 After ready, btn_i[4] high for 3 clocks then low -> buttons_o stays 8'hFF, changed_o stays 0.
//  4 After ready, btn_i=8'h81 stable 20 clocks, then rst_ni=0 for 1 clock ->
//    next edge buttons_o=8'hFF, ready_o=0; after release, ready_o re-rises 16 clocks later.
//  5 SOCD_FILTER_EN: after ready, btn_i=8'hC0 -> buttons_o=8'hFF.
//    Then btn_i=8'h40 -> buttons_o=8'hBF with one changed_o pulse.
//    Without the macro, btn_i=8'hC0 -> buttons_o=8'h3F.
//  6 After ready, btn_i 8'h00 -> 8'h0F on one edge -> all four bits flip on the same edge.
//    buttons_o=8'hF0, exactly one changed_o pulse.

Source files
------------

// File: rtl/pia_button_conditioner.sv
// Board-button conditioner for the PIA: 2-flop sync, per-bit debounce, power-on settle.
// Optional SOCD filtering of opposing directions is enabled by defining SOCD_FILTER_EN.
module pia_button_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STARTUP_CYCLES  = 1048576
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] btn_i,
  output logic [NUM_BUTTONS-1:0] buttons_o,
  output logic                   ready_o,
  output logic                   changed_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StW  = $clog2(STARTUP_CYCLES + 1);

  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StW-1:0]  StMax  = StW'(STARTUP_CYCLES - 1);

  localparam int unsigned BitUp    = 4;
  localparam int unsigned BitDown  = 5;
  localparam int unsigned BitLeft  = 6;
  localparam int unsigned BitRight = 7;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [CntW-1:0]        cnt_q [NUM_BUTTONS];
  logic [CntW-1:0]        cnt_d [NUM_BUTTONS];
  logic [StW-1:0]         st_cnt_q, st_cnt_d;
  logic                   ready_q, ready_d;
  logic                   ready_prev_q;
  logic [NUM_BUTTONS-1:0] prev_q;

  // Pressed vector in, pressed vector out; opposing directions cancel when enabled.
  function automatic logic [NUM_BUTTONS-1:0] filt(input logic [NUM_BUTTONS-1:0] p);
    logic [NUM_BUTTONS-1:0] r;
    r = p;
`ifdef SOCD_FILTER_EN
    if (p[BitLeft] && p[BitRight]) begin
      r[BitLeft]  = 1'b0;
      r[BitRight] = 1'b0;
    end
    if (p[BitUp] && p[BitDown]) begin
      r[BitUp]   = 1'b0;
      r[BitDown] = 1'b0;
    end
`endif
    return r;
  endfunction

  // A single matching sample clears the count, so only an unbroken run flips a bit.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Counter only advances while not ready, so it stops at STARTUP_CYCLES and never wraps.
  always_comb begin
    st_cnt_d = st_cnt_q;
    ready_d  = ready_q;
    if (!ready_q) begin
      st_cnt_d = st_cnt_q + 1'b1;
      if (st_cnt_q == StMax) begin
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      st_cnt_q     <= '0;
      ready_q      <= 1'b0;
      ready_prev_q <= 1'b0;
      prev_q       <= '1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      st_cnt_q     <= st_cnt_d;
      ready_q      <= ready_d;
      ready_prev_q <= ready_q;
      prev_q       <= buttons_o;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    buttons_o = ready_q ? ~filt(stable_q) : '1;
    ready_o   = ready_q;
    changed_o = ready_q & ready_prev_q & (buttons_o != prev_q);
  end

endmodule

// File: tb/tb_pia_button_conditioner.sv
// Scoreboard bench for pia_button_conditioner: expected buttons_o values are queued as stimulus
// is applied and popped on each changed_o pulse.
module tb_pia_button_conditioner;

  localparam int unsigned Nb = 8;
  localparam int unsigned Db = 4;
  localparam int unsigned St = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [Nb-1:0] btn = '0;
  logic [Nb-1:0] buttons;
  logic          ready;
  logic          changed;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  logic [Nb-1:0] exp_q [$];

  pia_button_conditioner #(
    .NUM_BUTTONS    (Nb),
    .DEBOUNCE_CYCLES(Db),
    .STARTUP_CYCLES (St)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .buttons_o(buttons),
    .ready_o  (ready),
    .changed_o(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Every changed_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) chk("unexpected_pulse", {24'h0, buttons}, 32'hdead);
      else chk("sb_buttons", {24'h0, buttons}, {24'h0, exp_q.pop_front()});
    end
  end

  // Releases reset and returns the number of edges until ready_o is seen high.
  task automatic release_and_count(output int n, output bit ff_ok);
    n = 0;
    ff_ok = 1'b1;
    rst_n = 1'b1;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (ready !== 1'b1 && buttons !== 8'hFF) ff_ok = 1'b0;
    end
  endtask

  task automatic wait_buttons(input logic [Nb-1:0] exp, output int m);
    m = 0;
    while (buttons !== exp && m < 30) begin
      tick();
      m++;
    end
  endtask

  initial begin
    int  n;
    int  m;
    int  p0;
    bit  ff_ok;
    bit  glitch_ok;

    // 1: reset and settle
    ticks(3);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_buttons", {24'h0, buttons}, 32'hFF);
    chk("rst_changed", {31'h0, changed}, 32'h0);
    release_and_count(n, ff_ok);
    chk("startup_edges", n, St);
    chk("startup_ff", {31'h0, ff_ok}, 32'h1);
    chk("ready_buttons", {24'h0, buttons}, 32'hFF);

    // 2: single press latency
    p0 = n_pulses;
    btn = 8'h10;
    exp_q.push_back(8'hEF);
    tick();
    wait_buttons(8'hEF, m);
    chk("press_latency", m, Db + 1);
    ticks(4);
    chk("press_pulses", n_pulses - p0, 1);
    btn = 8'h00;
    exp_q.push_back(8'hFF);
    ticks(10);

    // 3: short glitch is rejected
    p0 = n_pulses;
    glitch_ok = 1'b1;
    btn = 8'h10;
    ticks(3);
    btn = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (buttons !== 8'hFF) glitch_ok = 1'b0;
    end
    chk("glitch_stable", {31'h0, glitch_ok}, 32'h1);
    chk("glitch_pulses", n_pulses - p0, 0);

    // 4: reset mid-operation
    btn = 8'h81;
    exp_q.push_back(8'h7E);
    ticks(20);
    chk("held_buttons", {24'h0, buttons}, 32'h7E);
    rst_n = 1'b0;
    tick();
    chk("rerst_buttons", {24'h0, buttons}, 32'hFF);
    chk("rerst_ready", {31'h0, ready}, 32'h0);
    release_and_count(n, ff_ok);
    chk("restart_edges", n, St);
    chk("restart_buttons", {24'h0, buttons}, 32'h7E);
    btn = 8'h00;
    exp_q.push_back(8'hFF);
    ticks(10);

    // 5: opposing directions
    btn = 8'hC0;
`ifdef SOCD_FILTER_EN
    ticks(10);
    chk("socd_lr", {24'h0, buttons}, 32'hFF);
`else
    exp_q.push_back(8'h3F);
    ticks(10);
    chk("socd_lr", {24'h0, buttons}, 32'h3F);
`endif
    p0 = n_pulses;
    btn = 8'h40;
    exp_q.push_back(8'hBF);
    ticks(10);
    chk("socd_left", {24'h0, buttons}, 32'hBF);
    chk("socd_pulses", n_pulses - p0, 1);
    btn = 8'h00;
    exp_q.push_back(8'hFF);
    ticks(10);

    // 6: simultaneous multi-bit flip
    p0 = n_pulses;
    btn = 8'h0F;
    exp_q.push_back(8'hF0);
    ticks(10);
    chk("multi_buttons", {24'h0, buttons}, 32'hF0);
    chk("multi_pulses", n_pulses - p0, 1);
    btn = 8'h00;
    exp_q.push_back(8'hFF);
    ticks(10);

    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
